// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types and MEM stage state encoding
package cpu_types_pkg;

    localparam int ADDR_W = 32;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // MEM stage controller states, kept as plain constants for legacy tools
    typedef logic [1:0] memstate_t;
    localparam memstate_t IDLE   = 2'd0;
    localparam memstate_t ACCESS = 2'd1;
    localparam memstate_t DONE   = 2'd2;
    localparam memstate_t HALTED = 2'd3;

    // Memory operation captured from EX/MEM when the access starts
    typedef struct packed {
        logic rd;   // 1 = load, 0 = store
        logic ll;   // load-linked
        logic sc;   // store-conditional
    } mem_op_t;

endpackage

// File: rtl/llsc_link.sv
// rtl/llsc_link.sv - load-linked link register with coherence/store invalidation
module llsc_link
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  set_i,        // ll completed this cycle
    input  word_t set_addr_i,
    input  logic  inv_i,        // coherence invalidate strobe
    input  word_t inv_addr_i,
    input  logic  wr_i,         // own store completed this cycle
    input  word_t wr_addr_i,
    input  word_t chk_addr_i,   // address of the sc being decided
    output logic  match_o
);

    logic  valid_q, valid_d;
    word_t addr_q, addr_d;

    // Invalidate on a matching snoop or own store; a completing ll overrides both
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        if ((inv_i && (inv_addr_i == addr_q)) || (wr_i && (wr_addr_i == addr_q))) begin
            valid_d = 1'b0;
        end
        if (set_i) begin
            valid_d = 1'b1;
            addr_d  = set_addr_i;
        end
    end

    // Link register state
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
        end
    end

    assign match_o = valid_q && (addr_q == chk_addr_i);

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM stage dcache handshake, stall/flush, halt and perf counters (option: MEM_LLSC_EN)
module mem_stage_ctrl
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             dREN_i,
    input  logic             dWEN_i,
    input  logic             halt_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      store_i,
    input  logic             ll_i,
    input  logic             sc_i,
    input  logic             dhit,
    input  logic [31:0]      dmemload,
    input  logic             ccinv_i,
    input  logic [31:0]      ccsnoopaddr_i,
    output logic             dmemREN,
    output logic             dmemWEN,
    output logic [31:0]      dmemaddr,
    output logic [31:0]      dmemstore,
    output logic             pipe_stall_o,
    output logic             memwb_flush_o,
    output logic [31:0]      ldat_o,
    output logic             halt_o,
    output logic             err_o,
    output logic [CNT_W-1:0] acc_cnt_o,
    output logic [CNT_W-1:0] wait_cnt_o
);

    localparam logic        TMO_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LIM = 32'(TIMEOUT_CYCLES);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    memstate_t        state_q, state_d;
    mem_op_t          op_q, op_d;
    word_t            addr_q, addr_d;
    word_t            store_q, store_d;
    word_t            ldat_q, ldat_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [31:0]      tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             stall, flush;
    logic             link_set, link_wr;
    logic             sc_fail;

`ifdef MEM_LLSC_EN
    logic link_match;

    llsc_link u_link (
        .CLK        (CLK),
        .nRST       (nRST),
        .set_i      (link_set),
        .set_addr_i (addr_q),
        .inv_i      (ccinv_i),
        .inv_addr_i (ccsnoopaddr_i),
        .wr_i       (link_wr),
        .wr_addr_i  (addr_q),
        .chk_addr_i (addr_i),
        .match_o    (link_match)
    );

    // A failing sc never reaches the cache; it retires straight through DONE
    assign sc_fail = dWEN_i && !dREN_i && sc_i && !link_match;
`else
    logic unused_llsc;

    // Without link tracking ll is a plain load and sc always succeeds
    assign sc_fail     = 1'b0;
    assign unused_llsc = ^{ccinv_i, ccsnoopaddr_i, op_q.ll, link_set, link_wr};
`endif

    // Next-state, handshake and counter logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        addr_d   = addr_q;
        store_d  = store_q;
        ldat_d   = ldat_q;
        acc_d    = acc_q;
        wait_d   = wait_q;
        tmo_d    = tmo_q;
        err_d    = err_q;
        stall    = 1'b0;
        flush    = 1'b0;
        link_set = 1'b0;
        link_wr  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dREN_i || dWEN_i) begin
                    stall   = 1'b1;
                    flush   = 1'b1;
                    op_d.rd = dREN_i;
                    op_d.ll = ll_i & dREN_i;
                    op_d.sc = sc_i & ~dREN_i;
                    addr_d  = addr_i;
                    store_d = store_i;
                    if (sc_fail) begin
                        ldat_d  = '0;
                        state_d = DONE;
                    end else begin
                        tmo_d   = 32'd1;
                        state_d = ACCESS;
                    end
                end else if (halt_i) begin
                    state_d = HALTED;
                end
            end
            ACCESS: begin
                stall  = 1'b1;
                flush  = 1'b1;
                wait_d = sat_inc(wait_q);
                if (dhit) begin
                    if (op_q.rd) begin
                        ldat_d = dmemload;
                    end else begin
                        ldat_d = op_q.sc ? word_t'(1) : '0;
                    end
                    acc_d    = sat_inc(acc_q);
                    link_set = op_q.rd & op_q.ll;
                    link_wr  = ~op_q.rd;
                    state_d  = DONE;
                end else if (tmo_q != 32'hFFFF_FFFF) begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // tmo_d counts the ACCESS cycle about to be entered, so err_o rises during the limit cycle
        if (TMO_EN && (state_d == ACCESS) && (tmo_d >= TMO_LIM)) begin
            err_d = 1'b1;
        end
    end

    // Controller state, latched request and counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            store_q <= '0;
            ldat_q  <= '0;
            acc_q   <= '0;
            wait_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            ldat_q  <= ldat_d;
            acc_q   <= acc_d;
            wait_q  <= wait_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign dmemREN       = (state_q == ACCESS) &&  op_q.rd;
    assign dmemWEN       = (state_q == ACCESS) && !op_q.rd;
    assign dmemaddr      = addr_q;
    assign dmemstore     = store_q;
    assign pipe_stall_o  = stall;
    assign memwb_flush_o = flush;
    assign ldat_o        = ldat_q;
    assign halt_o        = (state_q == HALTED);
    assign err_o         = err_q;
    assign acc_cnt_o     = acc_q;
    assign wait_cnt_o    = wait_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - randomized self-checking bench for mem_stage_ctrl (option: MEM_LLSC_EN)
module tb_mem_stage_ctrl;

    logic        CLK = 1'b0;
    logic        nRST = 1'b1;
    logic        dREN_i = 1'b0, dWEN_i = 1'b0, halt_i = 1'b0;
    logic [31:0] addr_i = '0, store_i = '0;
    logic        ll_i = 1'b0, sc_i = 1'b0;
    logic        dhit = 1'b0;
    logic [31:0] dmemload = '0;
    logic        ccinv_i = 1'b0;
    logic [31:0] ccsnoopaddr_i = '0;
    logic        dmemREN, dmemWEN, pipe_stall_o, memwb_flush_o, halt_o, err_o;
    logic [31:0] dmemaddr, dmemstore, ldat_o;
    logic [15:0] acc_cnt_o, wait_cnt_o;

    mem_stage_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .dREN_i(dREN_i), .dWEN_i(dWEN_i), .halt_i(halt_i),
        .addr_i(addr_i), .store_i(store_i), .ll_i(ll_i), .sc_i(sc_i), .dhit(dhit),
        .dmemload(dmemload), .ccinv_i(ccinv_i), .ccsnoopaddr_i(ccsnoopaddr_i),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .pipe_stall_o(pipe_stall_o), .memwb_flush_o(memwb_flush_o), .ldat_o(ldat_o),
        .halt_o(halt_o), .err_o(err_o), .acc_cnt_o(acc_cnt_o), .wait_cnt_o(wait_cnt_o)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int          acc_m  = 0;
    int          wait_m = 0;
    bit          lv_m   = 0;
    logic [31:0] la_m   = '0;

    logic [31:0] pool [4] = '{32'h100, 32'h200, 32'h300, 32'h304};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One memory instruction held in EX/MEM until the stage releases it
    task automatic do_op(input bit rd, input bit ll, input bit sc, input logic [31:0] a,
                         input logic [31:0] d, input int lat, input logic [31:0] rdata);
        bit          go;
        bit          done;
        int          stall_n;
        int          req_n;
        logic [31:0] exp_ld;
`ifdef MEM_LLSC_EN
        go = rd || !sc || (lv_m && (la_m == a));
`else
        go = 1'b1;
`endif
        exp_ld = rd ? rdata : ((sc && go) ? 32'd1 : 32'd0);
        dREN_i = rd; dWEN_i = !rd; ll_i = ll; sc_i = sc;
        addr_i = a; store_i = d; dmemload = rdata; dhit = 1'b0;
        #1;
        stall_n = 0; req_n = 0; done = 0;
        check("req_flush", memwb_flush_o, 1);
        for (int c = 0; c < 32 && !done; c++) begin
            if (pipe_stall_o) stall_n++;
            if (dmemREN || dmemWEN) begin
                req_n++;
                if (req_n == 1) begin
                    check("req_ren", dmemREN, rd);
                    check("req_addr", dmemaddr, a);
                    if (!rd) check("req_store", dmemstore, d);
                end
                dhit = (req_n == lat);
            end else begin
                dhit = 1'b0;
            end
            if (!pipe_stall_o) begin
                done = 1;
                check("done_flush", memwb_flush_o, 0);
                check("done_ldat", ldat_o, exp_ld);
                dREN_i = 0; dWEN_i = 0; ll_i = 0; sc_i = 0;
            end
            @(negedge CLK); #1;
        end
        check("op_completed", done, 1);
        if (go) begin
            acc_m  += 1;
            wait_m += lat;
`ifdef MEM_LLSC_EN
            if (rd && ll) begin
                lv_m = 1; la_m = a;
            end else if (!rd && lv_m && (la_m == a)) begin
                lv_m = 0;
            end
`endif
        end
        check("stall_cycles", stall_n, go ? 1 + lat : 1);
        check("req_cycles", req_n, go ? lat : 0);
        check("acc_cnt", acc_cnt_o, acc_m);
        check("wait_cnt", wait_cnt_o, wait_m);
    endtask

    // Idle cycle with optional snoop invalidate and stray dhit
    task automatic idle_cyc(input bit inv, input logic [31:0] ia, input bit stray);
        ccinv_i = inv; ccsnoopaddr_i = ia; dhit = stray;
        @(negedge CLK); #1;
        ccinv_i = 0; dhit = 0;
`ifdef MEM_LLSC_EN
        if (inv && lv_m && (la_m == ia)) lv_m = 0;
`endif
        check("idle_no_req", dmemREN | dmemWEN, 0);
    endtask

    initial begin
        bit          rd, ll, sc;
        logic [31:0] a;
        #1 nRST = 1'b0;
        @(negedge CLK); #1;
        check("rst_stall", pipe_stall_o, 0);
        check("rst_req", dmemREN | dmemWEN, 0);
        check("rst_halt", halt_o, 0);
        check("rst_err", err_o, 0);
        check("rst_ldat", ldat_o, 0);
        check("rst_acc", acc_cnt_o, 0);
        check("rst_wait", wait_cnt_o, 0);
        nRST = 1'b1;
        @(negedge CLK); #1;

        do_op(1, 0, 0, 32'h100, 32'h0, 3, 32'hDEADBEEF);
        do_op(0, 0, 0, 32'h200, 32'h1234, 1, 32'h0);
`ifdef MEM_LLSC_EN
        do_op(1, 1, 0, 32'h300, 32'h0, 2, 32'h55);
        do_op(0, 0, 1, 32'h300, 32'hAB, 1, 32'h0);
        do_op(1, 1, 0, 32'h300, 32'h0, 1, 32'h66);
        idle_cyc(1, 32'h300, 0);
        do_op(0, 0, 1, 32'h300, 32'hCD, 2, 32'h0);
`else
        do_op(0, 0, 1, 32'h300, 32'h77, 2, 32'h0);
`endif

        for (int i = 0; i < 40; i++) begin
            rd = 1'($urandom_range(0, 1));
            ll = rd  ? 1'($urandom_range(0, 1)) : 1'b0;
            sc = !rd ? 1'($urandom_range(0, 1)) : 1'b0;
            a  = pool[$urandom_range(0, 3)];
            do_op(rd, ll, sc, a, $urandom, $urandom_range(1, 5), $urandom);
            if ($urandom_range(0, 2) == 0)
                idle_cyc(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
        end
        check("no_err_random", err_o, 0);

        // halt in the same instruction slot as a load: load first, then sticky halt
        halt_i = 1'b1;
        do_op(1, 0, 0, 32'h104, 32'h0, 2, 32'hCAFE0001);
        check("halt_not_yet", halt_o, 0);
        @(negedge CLK); #1;
        halt_i = 1'b0; dREN_i = 1'b1; addr_i = 32'h108;
        for (int k = 0; k < 4; k++) begin
            check("halted_halt", halt_o, 1);
            check("halted_stall", pipe_stall_o, 1);
            check("halted_no_req", dmemREN | dmemWEN, 0);
            @(negedge CLK); #1;
        end
        dREN_i = 1'b0;

        // timeout: dhit never arrives
        nRST = 1'b0; #1; nRST = 1'b1;
        @(negedge CLK); #1;
        dREN_i = 1'b1; addr_i = 32'h400;
        @(negedge CLK); #1;
        for (int k = 1; k <= 10; k++) begin
            check("tmo_err", err_o, (k >= 8) ? 32'd1 : 32'd0);
            check("tmo_req_held", dmemREN, 1);
            @(negedge CLK); #1;
        end

        // asynchronous reset in the middle of the stuck access
        dREN_i = 1'b0; nRST = 1'b0; #1;
        check("arst_req", dmemREN | dmemWEN, 0);
        check("arst_stall", pipe_stall_o, 0);
        check("arst_err", err_o, 0);
        check("arst_wait", wait_cnt_o, 0);
        check("arst_addr", dmemaddr, 0);
        check("arst_halt", halt_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
